// File: rtl/i2c_reg_master.sv
// I2C initiator for single-byte register write/read transactions.
// Drives open-drain pull-low enables; samples pad levels for ACK, data and stretching.
module i2c_reg_master #(
  parameter int         CLK_DIV  = 250,
  parameter logic [6:0] DEV_ADDR = 7'h68
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] regAddr,
  input  logic [7:0] wrData,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdData,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, START, TXBIT, RXACK, RSTART, RXBIT, TXNACK, STOP
  } state_t;

  state_t state, stateNext;

  logic [DW-1:0] div;
  logic [1:0]    q;
  logic [2:0]    bitCnt;
  logic [1:0]    byteSel;
  logic [7:0]    txSh, rxSh, regQ, dataQ;
  logic          rwQ, ackBit;
  logic          freeze, tick, bitEnd, accept, sclLowQ;

  // A slave holding SCL low after release freezes the Q1 phase.
  assign freeze  = (state != IDLE) && (q == 2'd1) && !scl_i;
  assign tick    = (state != IDLE) && !freeze && (div == DW'(CLK_DIV - 1));
  assign bitEnd  = tick && (q == 2'd3);
  assign accept  = (state == IDLE) && start && !done;
  assign sclLowQ = (q == 2'd0) || (q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (accept) stateNext = START;
      START:  if (bitEnd) stateNext = TXBIT;
      TXBIT:  if (bitEnd && bitCnt == 3'd0) stateNext = RXACK;
      RXACK: begin
        if (bitEnd) begin
          if (ackBit) stateNext = STOP;
          else begin
            case (byteSel)
              2'd0:    stateNext = TXBIT;
              2'd1:    stateNext = rwQ ? RSTART : TXBIT;
              2'd2:    stateNext = STOP;
              default: stateNext = RXBIT;
            endcase
          end
        end
      end
      RSTART: if (bitEnd) stateNext = TXBIT;
      RXBIT:  if (bitEnd && bitCnt == 3'd0) stateNext = TXNACK;
      TXNACK: if (bitEnd) stateNext = STOP;
      STOP:   if (bitEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      IDLE: ;
      START: begin
        scl_oe = (q == 2'd3);
        sda_oe = q[1];
      end
      RSTART: begin
        scl_oe = sclLowQ;
        sda_oe = q[1];
      end
      TXBIT: begin
        scl_oe = sclLowQ;
        sda_oe = ~txSh[7];
      end
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q != 2'd3);
      end
      default: scl_oe = sclLowQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      q       <= '0;
      bitCnt  <= '0;
      byteSel <= '0;
      txSh    <= '0;
      rxSh    <= '0;
      regQ    <= '0;
      dataQ   <= '0;
      rwQ     <= 1'b0;
      ackBit  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdData  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        div <= '0;
        q   <= '0;
      end else if (!freeze) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) q <= q + 2'd1;
      end
      if (accept) begin
        rwQ     <= rw;
        regQ    <= regAddr;
        dataQ   <= wrData;
        busy    <= 1'b1;
        ack_err <= 1'b0;
      end
      if (tick && q == 2'd2) begin
        if (state == RXACK) ackBit <= sda_i;
        if (state == RXBIT) rxSh <= {rxSh[6:0], sda_i};
      end
      if (bitEnd) begin
        case (state)
          START: begin
            txSh    <= {DEV_ADDR, 1'b0};
            bitCnt  <= 3'd7;
            byteSel <= 2'd0;
          end
          TXBIT: begin
            txSh   <= {txSh[6:0], 1'b0};
            bitCnt <= bitCnt - 3'd1;
          end
          RXACK: begin
            bitCnt <= 3'd7;
            if (ackBit) ack_err <= 1'b1;
            else if (byteSel == 2'd0) begin
              txSh    <= regQ;
              byteSel <= 2'd1;
            end else if (byteSel == 2'd1 && !rwQ) begin
              txSh    <= dataQ;
              byteSel <= 2'd2;
            end
          end
          RSTART: begin
            txSh    <= {DEV_ADDR, 1'b1};
            bitCnt  <= 3'd7;
            byteSel <= 2'd3;
          end
          RXBIT:  bitCnt <= bitCnt - 3'd1;
          TXNACK: rdData <= rxSh;
          STOP: begin
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
